fpmac_seq: RTL

Operand sequencer and result collector for the team's pipelined fp16 MAC (`fpmac`). It accepts a stream of (activation, weight) pairs terminated by a `last` flag and drives `fpmac`'s `in`/`weight`/`acc` ports every cycle. Returning MAC results are captured and written back into interleaved partial-sum lanes. At end of vector it reduces the lanes through the same MAC and presents one fp16 dot product with status flags.

---
 rtl/fpmac_seq.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fpmac_seq.sv
// fpmac_seq: operand sequencer and result collector for the pipelined fp16 MAC.
// Streams (activation, weight) pairs into interleaved partial-sum lanes,
// drains the MAC pipeline, reduces the lanes through the same MAC and
// presents a single fp16 dot product with overflow/subnormal status.
//
// Optional feature: define FPMAC_SEQ_RELU_EN to clamp negative results to
// +0 on res_data (status flags are never altered).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RUN   | accepting pairs, one per cycle, lane k mod LANES
// S_DRAIN | last pair taken, waiting for in-flight lane results
// S_REDUCE| reduction op for lane i is on the mac_* operands
// S_RWAIT | waiting for the reduction op to come back on mac_out
// S_DONE  | dot product presented, waiting for res_ready
module fpmac_seq #(
    parameter int MAC_LAT = 12
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [15:0] in_weight,
    input  logic        in_last,
    output logic [15:0] mac_in,
    output logic [15:0] mac_weight,
    output logic [15:0] mac_acc,
    input  logic [15:0] mac_out,
    input  logic        mac_overflow,
    input  logic        mac_sub,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_overflow,
    output logic        res_sub
);

    localparam int LANES = MAC_LAT + 1;
    localparam int LW    = $clog2(LANES);
    localparam int CW    = $clog2(MAC_LAT + 1);
    localparam logic [15:0] FP16_ONE = 16'h3C00;

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_DRAIN  = 3'd1,
        S_REDUCE = 3'd2,
        S_RWAIT  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t         state_q, state_d;

    logic [15:0]    lane_q   [LANES];
    logic [15:0]    lane_fwd [LANES];
    logic [LW-1:0]  lane_idx_q, lane_idx_d;
    logic [LW-1:0]  red_idx_q, red_idx_d;
    logic [LW-1:0]  red_nxt;
    logic [15:0]    running_q, running_d;
    logic           ovf_q;
    logic           sub_q, sub_d;
    logic           clear_vec;

    logic [15:0]    mac_in_q, mac_in_d;
    logic [15:0]    mac_weight_q, mac_weight_d;
    logic [15:0]    mac_acc_q, mac_acc_d;
    logic           iss_v_q, iss_v_d;
    logic [LW-1:0]  iss_lane_q, iss_lane_d;

    logic [MAC_LAT-1:0] tag_v_q;
    logic [LW-1:0]      tag_lane_q [MAC_LAT];
    logic               tag_out_v;
    logic [LW-1:0]      tag_out_lane;

    logic [CW-1:0]  infl_q, infl_d;
    logic           drain_empty;
    logic [15:0]    res_val;

    assign tag_out_v    = tag_v_q[MAC_LAT-1];
    assign tag_out_lane = tag_lane_q[MAC_LAT-1];
    assign red_nxt      = red_idx_q + 1'b1;

    // Lane view including the result landing this cycle, so a lane reused
    // exactly LANES cycles later (or read at drain exit) sees the fresh sum.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_fwd[j] = (tag_out_v && (tag_out_lane == LW'(j))) ? mac_out : lane_q[j];
        end
    end

    // Nothing left in flight once this cycle's writeback (if any) lands.
    assign drain_empty = !iss_v_q && (infl_q == {{(CW-1){1'b0}}, tag_out_v});

    // Next-state, operand and issue-tag selection.
    always_comb begin
        state_d      = state_q;
        lane_idx_d   = lane_idx_q;
        red_idx_d    = red_idx_q;
        running_d    = running_q;
        sub_d        = sub_q;
        clear_vec    = 1'b0;
        mac_in_d     = 16'h0000;
        mac_weight_d = 16'h0000;
        mac_acc_d    = 16'h0000;
        iss_v_d      = 1'b0;
        iss_lane_d   = '0;

        case (state_q)
            S_RUN: begin
                if (in_valid) begin
                    mac_in_d     = in_data;
                    mac_weight_d = in_weight;
                    mac_acc_d    = lane_fwd[lane_idx_q];
                    iss_v_d      = 1'b1;
                    iss_lane_d   = lane_idx_q;
                    lane_idx_d   = (lane_idx_q == LW'(LANES - 1)) ? '0 : lane_idx_q + 1'b1;
                    if (in_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_empty) begin
                    running_d    = lane_fwd[0];
                    red_idx_d    = LW'(1);
                    mac_in_d     = lane_fwd[1];
                    mac_weight_d = FP16_ONE;
                    mac_acc_d    = lane_fwd[0];
                    iss_v_d      = 1'b1;
                    iss_lane_d   = LW'(1);
                    state_d      = S_REDUCE;
                end
            end
            S_REDUCE: begin
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (tag_out_v) begin
                    running_d = mac_out;
                    sub_d     = mac_sub;
                    if (red_idx_q == LW'(LANES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        red_idx_d    = red_nxt;
                        mac_in_d     = lane_fwd[red_nxt];
                        mac_weight_d = FP16_ONE;
                        mac_acc_d    = mac_out;
                        iss_v_d      = 1'b1;
                        iss_lane_d   = red_nxt;
                        state_d      = S_REDUCE;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    clear_vec  = 1'b1;
                    lane_idx_d = '0;
                    red_idx_d  = '0;
                    running_d  = 16'h0000;
                    sub_d      = 1'b0;
                    state_d    = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // In-flight count tracks tags in the pipe: +1 on issue, -1 on return.
    assign infl_d = infl_q + CW'(iss_v_q) - CW'(tag_out_v);

    // Control state, indices, running sum and status flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_RUN;
            lane_idx_q <= '0;
            red_idx_q  <= '0;
            running_q  <= 16'h0000;
            sub_q      <= 1'b0;
            ovf_q      <= 1'b0;
            infl_q     <= '0;
        end else begin
            state_q    <= state_d;
            lane_idx_q <= lane_idx_d;
            red_idx_q  <= red_idx_d;
            running_q  <= running_d;
            sub_q      <= sub_d;
            infl_q     <= infl_d;
            if (clear_vec) begin
                ovf_q <= 1'b0;
            end else if (tag_out_v && mac_overflow) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Registered MAC operands and the issue tag that travels with them.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mac_in_q     <= 16'h0000;
            mac_weight_q <= 16'h0000;
            mac_acc_q    <= 16'h0000;
            iss_v_q      <= 1'b0;
            iss_lane_q   <= '0;
        end else begin
            mac_in_q     <= mac_in_d;
            mac_weight_q <= mac_weight_d;
            mac_acc_q    <= mac_acc_d;
            iss_v_q      <= iss_v_d;
            iss_lane_q   <= iss_lane_d;
        end
    end

    // Tag pipe: output lines up with the MAC result MAC_LAT cycles after issue.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tag_v_q <= '0;
            for (int k = 0; k < MAC_LAT; k++) begin
                tag_lane_q[k] <= '0;
            end
        end else begin
            tag_v_q[0]    <= iss_v_q;
            tag_lane_q[0] <= iss_lane_q;
            for (int k = 1; k < MAC_LAT; k++) begin
                tag_v_q[k]    <= tag_v_q[k-1];
                tag_lane_q[k] <= tag_lane_q[k-1];
            end
        end
    end

    // Partial-sum lanes: written back from tagged results, cleared on handshake.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int j = 0; j < LANES; j++) begin
                lane_q[j] <= 16'h0000;
            end
        end else if (clear_vec) begin
            for (int j = 0; j < LANES; j++) begin
                lane_q[j] <= 16'h0000;
            end
        end else begin
            for (int j = 0; j < LANES; j++) begin
                lane_q[j] <= lane_fwd[j];
            end
        end
    end

    // Result presentation, optionally clamping negative sums to +0.
    always_comb begin
`ifdef FPMAC_SEQ_RELU_EN
        res_val = running_q[15] ? 16'h0000 : running_q;
`else
        res_val = running_q;
`endif
    end

    assign in_ready     = (state_q == S_RUN);
    assign res_valid    = (state_q == S_DONE);
    assign res_data     = res_valid ? res_val : 16'h0000;
    assign res_overflow = res_valid & ovf_q;
    assign res_sub      = res_valid & sub_q;
    assign mac_in       = mac_in_q;
    assign mac_weight   = mac_weight_q;
    assign mac_acc      = mac_acc_q;

endmodule
